// File: rtl/painterengine_gpu_writer_scheduler_if.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_writer_scheduler_if
// Bundles the requester-side and writer-side signals of the GPU writer
// scheduler. Signal prefixes are from the scheduler's point of view.
//
// Handshake: a requester holds i_wire_request[k] high until it sees a one-cycle
// pulse on o_wire_done[k] or o_wire_error[k], and drops it on the following
// cycle. The writer is only out of reset (o_wire_writer_resetn=1) while it owns
// a job; i_wire_writer_done/i_wire_writer_error are levels sampled only then.
//
// Signals
//   i_wire_request        4  per-channel level request
//   o_wire_grant          4  one-hot owning channel, 0 when none
//   o_wire_done           4  one-cycle job-complete pulse on the owning channel
//   o_wire_error          4  one-cycle error/timeout pulse on the owning channel
//   o_wire_busy           1  high whenever the scheduler is not idle
//   o_wire_writer_resetn  1  writer reset, active-low
//   o_wire_writer_router  4  one-hot router presented to the writer
//   i_wire_writer_done    1  writer done level
//   i_wire_writer_error   1  writer error level
//   o_dbg_state           2  current scheduler state (debug)
// Modports: master = scheduler, slave = channels + writer side.
// ----------------------------------------------------------------------------
interface painterengine_gpu_writer_scheduler_if;
    logic [3:0] i_wire_request;
    logic [3:0] o_wire_grant;
    logic [3:0] o_wire_done;
    logic [3:0] o_wire_error;
    logic       o_wire_busy;
    logic       o_wire_writer_resetn;
    logic [3:0] o_wire_writer_router;
    logic       i_wire_writer_done;
    logic       i_wire_writer_error;
    logic [1:0] o_dbg_state;

    modport master (
        input  i_wire_request, i_wire_writer_done, i_wire_writer_error,
        output o_wire_grant, o_wire_done, o_wire_error, o_wire_busy,
               o_wire_writer_resetn, o_wire_writer_router, o_dbg_state
    );

    modport slave (
        output i_wire_request, i_wire_writer_done, i_wire_writer_error,
        input  o_wire_grant, o_wire_done, o_wire_error, o_wire_busy,
               o_wire_writer_resetn, o_wire_writer_router, o_dbg_state
    );
endinterface

// File: rtl/painterengine_gpu_writer_scheduler.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_writer_scheduler
// Round-robin scheduler sharing one GPU DMA writer between 4 channels. It picks
// a requester, drives the writer's one-hot router, holds the writer in reset for
// PARAM_RESET_CYCLES, releases it for exactly one job and reports done/error
// back to the owning channel. A job with no writer response for PARAM_TIMEOUT
// RUN cycles is aborted with an error pulse.
//
// Ports
//   i_wire_clock  1  clock
//   i_wire_reset  1  synchronous active-high reset
//   io_bus           scheduler side (master) of the scheduler interface
// All outputs are registered.
// ----------------------------------------------------------------------------
module painterengine_gpu_writer_scheduler #(
    parameter int PARAM_RESET_CYCLES = 2,
    parameter int PARAM_TIMEOUT      = 65536
) (
    input  logic i_wire_clock,
    input  logic i_wire_reset,
    painterengine_gpu_writer_scheduler_if.master io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RST    = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [7:0]  r_rst_cnt;
    logic [31:0] r_to_cnt;
    logic [3:0]  r_grant;
    logic [3:0]  r_done;
    logic [3:0]  r_error;
    logic        r_busy;
    logic        r_resetn;

    logic        w_found;
    logic [1:0]  w_pick;
    logic [1:0]  w_idx;

    // Round-robin search starting one past the last grant; the 2-bit add wraps
    // channel 3 back to channel 0, and i=4 lands on the last granted channel.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && io_bus.i_wire_request[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd3;
            r_rst_cnt <= 8'd0;
            r_to_cnt  <= 32'd0;
            r_grant   <= 4'd0;
            r_done    <= 4'd0;
            r_error   <= 4'd0;
            r_busy    <= 1'b0;
            r_resetn  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= 4'b0001 << w_pick;
                        r_ptr     <= w_pick;
                        r_rst_cnt <= 8'd0;
                        r_busy    <= 1'b1;
                        r_resetn  <= 1'b0;
                        r_state   <= S_RST;
                    end
                end
                S_RST: begin
                    // Router was registered on entry, so it is stable before
                    // resetn rises.
                    if (r_rst_cnt == 8'(PARAM_RESET_CYCLES - 1)) begin
                        r_resetn <= 1'b1;
                        r_to_cnt <= 32'd0;
                        r_state  <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    // Writer error outranks done, which outranks the timeout.
                    if (io_bus.i_wire_writer_error) begin
                        r_error  <= r_grant;
                        r_resetn <= 1'b0;
                        r_state  <= S_REPORT;
                    end else if (io_bus.i_wire_writer_done) begin
                        r_done   <= r_grant;
                        r_resetn <= 1'b0;
                        r_state  <= S_REPORT;
                    end else if (r_to_cnt == 32'(PARAM_TIMEOUT - 1)) begin
                        r_error  <= r_grant;
                        r_resetn <= 1'b0;
                        r_state  <= S_REPORT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end
                S_REPORT: begin
                    r_done  <= 4'd0;
                    r_error <= 4'd0;
                    r_grant <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.o_wire_grant         = r_grant;
    assign io_bus.o_wire_writer_router = r_grant;
    assign io_bus.o_wire_done          = r_done;
    assign io_bus.o_wire_error         = r_error;
    assign io_bus.o_wire_busy          = r_busy;
    assign io_bus.o_wire_writer_resetn = r_resetn;
    assign io_bus.o_dbg_state          = r_state;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
module tb_painterengine_gpu_writer_scheduler;

    localparam int RC = 2;
    localparam int TO = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    painterengine_gpu_writer_scheduler_if bus_if ();

    painterengine_gpu_writer_scheduler #(
        .PARAM_RESET_CYCLES(RC),
        .PARAM_TIMEOUT     (TO)
    ) dut (
        .i_wire_clock(clk),
        .i_wire_reset(rst),
        .io_bus      (bus_if.master)
    );

    int vectors = 0;
    int fails   = 0;

    // {run_len[13:0], busy, resetn, router, grant, done, error}
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int run, input logic [3:0] g,
                                       input logic [3:0] d, input logic [3:0] e);
        logic [13:0] r;
        r = 14'(run);
        return {r, 1'b1, 1'b0, g, g, d, e};
    endfunction

    // ---------------- writer model ----------------
    // mode 0: done, 1: error, 2: never responds. Response level rises once the
    // writer has been out of reset for more than wr_delay cycles, so the
    // scheduler spends wr_delay+1 cycles in RUN.
    int wr_mode  = 0;
    int wr_delay = 5;
    int wr_cnt   = 0;

    initial begin
        bus_if.i_wire_request      = 4'd0;
        bus_if.i_wire_writer_done  = 1'b0;
        bus_if.i_wire_writer_error = 1'b0;
    end

    always @(negedge clk) begin
        if (!bus_if.o_wire_writer_resetn) begin
            wr_cnt = 0;
            bus_if.i_wire_writer_done  = 1'b0;
            bus_if.i_wire_writer_error = 1'b0;
        end else begin
            wr_cnt++;
            if (wr_mode != 2 && wr_cnt > wr_delay) begin
                bus_if.i_wire_writer_done  = (wr_mode == 0);
                bus_if.i_wire_writer_error = (wr_mode == 1);
            end
        end
    end

    // ---------------- monitor ----------------
    int lowcnt     = 0;
    int run_cycles = 0;
    bit seen_run   = 0;
    bit chk_idle   = 0;

    always @(negedge clk) begin
        if (chk_idle) begin
            chk_idle = 0;
            check("post_report_idle",
                  {18'd0, bus_if.o_wire_grant, bus_if.o_wire_busy,
                   bus_if.o_wire_writer_resetn, bus_if.o_wire_done, bus_if.o_wire_error},
                  32'd0);
        end
        if ((bus_if.o_wire_done | bus_if.o_wire_error) != 4'd0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_pulse: got done=%b error=%b expected none",
                         bus_if.o_wire_done, bus_if.o_wire_error);
            end else begin
                check("job_result",
                      {14'(run_cycles), bus_if.o_wire_busy, bus_if.o_wire_writer_resetn,
                       bus_if.o_wire_writer_router, bus_if.o_wire_grant,
                       bus_if.o_wire_done, bus_if.o_wire_error},
                      exp_q.pop_front());
            end
            chk_idle = 1;
        end
        if (bus_if.o_wire_grant == 4'd0) begin
            lowcnt = 0; run_cycles = 0; seen_run = 0;
        end else if (bus_if.o_wire_writer_resetn) begin
            if (!seen_run) begin
                seen_run = 1;
                check("reset_hold", 32'(lowcnt), 32'(RC));
            end
            run_cycles++;
        end else if (!seen_run) begin
            lowcnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pulses(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ((bus_if.o_wire_done | bus_if.o_wire_error) != 4'd0) seen++;
        end
        if (seen < n) begin
            vectors++;
            fails++;
            $display("FAIL pulse_timeout: got %0d pulses expected %0d", seen, n);
        end
    endtask

    task automatic wait_resetn(input int budget);
        int cyc = 0;
        while (!bus_if.o_wire_writer_resetn && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus_if.o_wire_writer_resetn) begin
            vectors++;
            fails++;
            $display("FAIL resetn_timeout: got resetn=0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.i_wire_request = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string name, input int cycles);
        repeat (cycles) @(negedge clk);
        check(name, {27'd0, bus_if.o_wire_busy, bus_if.o_wire_grant}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        @(negedge clk);
        check("reset_state",
              {18'd0, bus_if.o_wire_grant, bus_if.o_wire_writer_router,
               bus_if.o_wire_done, bus_if.o_wire_error, bus_if.o_wire_busy,
               bus_if.o_wire_writer_resetn, bus_if.o_dbg_state},
              32'd0);

        // single request on ch2, done 10 cycles after release
        wr_mode = 0; wr_delay = 10;
        exp_q.push_back(mk(11, 4'b0100, 4'b0100, 4'b0000));
        bus_if.i_wire_request = 4'b0100;
        wait_pulses(1, 100);
        bus_if.i_wire_request = 4'b0000;
        check_quiet("t1_no_regrant", 8);

        // all four held: full rotation and wrap
        do_reset();
        wr_mode = 0; wr_delay = 5;
        exp_q.push_back(mk(6, 4'b0001, 4'b0001, 4'b0000));
        exp_q.push_back(mk(6, 4'b0010, 4'b0010, 4'b0000));
        exp_q.push_back(mk(6, 4'b0100, 4'b0100, 4'b0000));
        exp_q.push_back(mk(6, 4'b1000, 4'b1000, 4'b0000));
        exp_q.push_back(mk(6, 4'b0001, 4'b0001, 4'b0000));
        bus_if.i_wire_request = 4'b1111;
        wait_pulses(5, 400);
        bus_if.i_wire_request = 4'b0000;

        // sparse pattern from a fresh pointer
        do_reset();
        exp_q.push_back(mk(6, 4'b0001, 4'b0001, 4'b0000));
        exp_q.push_back(mk(6, 4'b0100, 4'b0100, 4'b0000));
        exp_q.push_back(mk(6, 4'b0001, 4'b0001, 4'b0000));
        bus_if.i_wire_request = 4'b0101;
        wait_pulses(3, 300);
        bus_if.i_wire_request = 4'b0000;

        // writer error on ch1
        wr_mode = 1; wr_delay = 3;
        exp_q.push_back(mk(4, 4'b0010, 4'b0000, 4'b0010));
        bus_if.i_wire_request = 4'b0010;
        wait_pulses(1, 100);
        bus_if.i_wire_request = 4'b0000;
        check_quiet("t3_idle_after_error", 4);

        // timeout on ch0, then a normal job on ch1
        wr_mode = 2;
        exp_q.push_back(mk(TO, 4'b0001, 4'b0000, 4'b0001));
        bus_if.i_wire_request = 4'b0001;
        wait_pulses(1, 300);
        bus_if.i_wire_request = 4'b0000;
        wr_mode = 0; wr_delay = 4;
        exp_q.push_back(mk(5, 4'b0010, 4'b0010, 4'b0000));
        bus_if.i_wire_request = 4'b0010;
        wait_pulses(1, 100);
        bus_if.i_wire_request = 4'b0000;

        // reset mid-RUN on ch3: no pulse, pointer back to 3
        wr_mode = 2;
        bus_if.i_wire_request = 4'b1000;
        wait_resetn(50);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus_if.i_wire_request = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        check("t5_after_reset",
              {23'd0, bus_if.o_wire_grant, bus_if.o_wire_writer_resetn,
               bus_if.o_wire_busy, bus_if.o_wire_done == 4'd0 && bus_if.o_wire_error == 4'd0,
               bus_if.o_dbg_state},
              {23'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0});
        wr_mode = 0; wr_delay = 5;
        exp_q.push_back(mk(6, 4'b0001, 4'b0001, 4'b0000));
        bus_if.i_wire_request = 4'b1111;
        wait_pulses(1, 100);
        bus_if.i_wire_request = 4'b0000;

        // ch2 drops its request mid-job; job still completes
        wr_mode = 0; wr_delay = 12;
        exp_q.push_back(mk(13, 4'b0100, 4'b0100, 4'b0000));
        bus_if.i_wire_request = 4'b0100;
        wait_resetn(50);
        repeat (2) @(negedge clk);
        bus_if.i_wire_request = 4'b0000;
        wait_pulses(1, 100);
        check_quiet("t6_no_regrant", 10);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
